mdu_ctrl: RTL and testbench

//  Multiply/divide sequencer and HI/LO register owner for the EX stage.

---
 rtl/mdu_ctrl_pkg.sv | 21 ++
 rtl/mdu_ctrl_if.sv | 26 ++
 rtl/mdu_ctrl_div_core.sv | 77 +++++++
 rtl/mdu_ctrl.sv | 122 ++++++++++++
 tb/tb_mdu_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared constants for the multiply/divide unit: EX-stage op codes and FSM states.
package mdu_ctrl_pkg;

    localparam int MDU_N = 32;

    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_BUSY = 2'b01,
        MDU_DONE = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage <-> multiply/divide unit bundle; names are seen from the MDU side.
interface mdu_ctrl_if #(parameter int N = 32) ();

    logic           valid_i;
    logic [7:0]     op_i;
    logic [N-1:0]   a_i;
    logic [N-1:0]   b_i;
    logic [2*N-1:0] prod_i;
    logic           flush_i;
    logic           stall_o;
    logic           done_o;
    logic [N-1:0]   hi_o;
    logic [N-1:0]   lo_o;
    logic [N-1:0]   rdata_o;

    modport master (
        output valid_i, op_i, a_i, b_i, prod_i, flush_i,
        input  stall_o, done_o, hi_o, lo_o, rdata_o
    );

    modport slave (
        input  valid_i, op_i, a_i, b_i, prod_i, flush_i,
        output stall_o, done_o, hi_o, lo_o, rdata_o
    );

endinterface

// File: rtl/mdu_ctrl_div_core.sv
// Unsigned N-bit restoring divider: one quotient bit per cycle after start_i.
module div_core #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [N-1:0] dividend_i,
    input  logic [N-1:0] divisor_i,
    output logic [N-1:0] quot_o,
    output logic [N-1:0] rem_o,
    output logic         lastStep_o
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] count_q, count_d;
    logic          running_q, running_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  divisor_q, divisor_d;
    logic [N:0]    trial;

    // Shift the next dividend bit into the remainder and subtract the divisor when it fits.
    always_comb begin
        count_d    = count_q;
        running_d  = running_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        trial      = {rem_q, quot_q[N-1]};
        lastStep_o = running_q && (count_q == CW'(N - 1));
        if (abort_i) begin
            running_d = 1'b0;
        end else if (start_i) begin
            quot_d    = dividend_i;
            rem_d     = '0;
            divisor_d = divisor_i;
            count_d   = '0;
            running_d = 1'b1;
        end else if (running_q) begin
            if (trial >= {1'b0, divisor_q}) begin
                rem_d  = N'(trial - {1'b0, divisor_q});
                quot_d = {quot_q[N-2:0], 1'b1};
            end else begin
                rem_d  = trial[N-1:0];
                quot_d = {quot_q[N-2:0], 1'b0};
            end
            count_d = count_q + CW'(1);
            if (lastStep_o) begin
                running_d = 1'b0;
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            running_q <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
        end else begin
            count_q   <= count_d;
            running_q <= running_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
        end
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer and HI/LO owner for the EX stage.
module mdu_ctrl #(
    parameter int           N        = 32,
    parameter logic [N-1:0] HILO_RST = '0
) (
    input  logic     clk,
    input  logic     rst,
    mdu_ctrl_if.slave bus
);

    import mdu_ctrl_pkg::*;

    mdu_state_e   state_q, state_d;
    logic [N-1:0] hi_q, hi_d;
    logic [N-1:0] lo_q, lo_d;
    logic         signQuot_q, signQuot_d;
    logic         signRem_q, signRem_d;
    logic         isSigned;
    logic         divStart, divAbort, divLast;
    logic [N-1:0] divDividend, divDivisor, divQuot, divRem;
    logic         stall, done;

    // Signed divides run on magnitudes; the most negative value maps onto itself, which is correct unsigned.
    always_comb begin
        isSigned    = (bus.op_i == EXE_DIV_OP);
        divDividend = (isSigned && bus.a_i[N-1]) ? -bus.a_i : bus.a_i;
        divDivisor  = (isSigned && bus.b_i[N-1]) ? -bus.b_i : bus.b_i;
    end

    div_core #(.N(N)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (divStart),
        .abort_i    (divAbort),
        .dividend_i (divDividend),
        .divisor_i  (divDivisor),
        .quot_o     (divQuot),
        .rem_o      (divRem),
        .lastStep_o (divLast)
    );

    // Next state, HI/LO updates and pipeline handshake; a flush overrides everything.
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        signQuot_d = signQuot_q;
        signRem_d  = signRem_q;
        divStart   = 1'b0;
        divAbort   = 1'b0;
        stall      = 1'b0;
        done       = 1'b0;
        if (bus.flush_i) begin
            state_d  = MDU_IDLE;
            divAbort = 1'b1;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (bus.valid_i) begin
                        case (bus.op_i)
                            EXE_MULT_OP, EXE_MULTU_OP: {hi_d, lo_d} = bus.prod_i;
                            EXE_MTHI_OP:               hi_d = bus.a_i;
                            EXE_MTLO_OP:               lo_d = bus.a_i;
                            EXE_DIV_OP, EXE_DIVU_OP: begin
                                if (bus.b_i == '0) begin
                                    hi_d = bus.a_i;
                                    lo_d = '1;
                                    done = 1'b1;
                                end else begin
                                    divStart   = 1'b1;
                                    signQuot_d = isSigned && (bus.a_i[N-1] ^ bus.b_i[N-1]);
                                    signRem_d  = isSigned && bus.a_i[N-1];
                                    stall      = 1'b1;
                                    state_d    = MDU_BUSY;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                MDU_BUSY: begin
                    stall = 1'b1;
                    if (divLast) begin
                        state_d = MDU_DONE;
                    end
                end
                MDU_DONE: begin
                    lo_d    = signQuot_q ? -divQuot : divQuot;
                    hi_d    = signRem_q ? -divRem : divRem;
                    done    = 1'b1;
                    state_d = MDU_IDLE;
                end
                default: state_d = MDU_IDLE;
            endcase
        end
    end

    // FSM, sign flags and HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MDU_IDLE;
            hi_q       <= HILO_RST;
            lo_q       <= HILO_RST;
            signQuot_q <= 1'b0;
            signRem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            signQuot_q <= signQuot_d;
            signRem_q  <= signRem_d;
        end
    end

    assign bus.stall_o = stall;
    assign bus.done_o  = done;
    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;
    assign bus.rdata_o = (bus.op_i == EXE_MFHI_OP) ? hi_q :
                         (bus.op_i == EXE_MFLO_OP) ? lo_q : '0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: multiply commit, divides, divide-by-zero, flush/reset abort, MT*/MF*.
module tb_mdu_ctrl;

    import mdu_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   checkCount = 0;
    int   passCount  = 0;
    int   stallCycles;
    int   doneCycles;

    mdu_ctrl_if #(.N(32)) bus ();

    mdu_ctrl #(.N(32), .HILO_RST(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive inputs just after a falling edge, then let combinational outputs settle.
    task automatic applyStimulus(input logic valid, input logic [7:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [63:0] prod, input logic flush);
        bus.valid_i = valid;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.prod_i  = prod;
        bus.flush_i = flush;
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 8'h00, 32'h0, 32'h0, 64'h0, 1'b0);
    endtask

    task automatic stepClock();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold a divide in EX until the cycle with stall_o low has been clocked, counting stall and done cycles.
    task automatic runDiv(input string tag, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output int dones);
        bit finished;
        finished = 1'b0;
        stalls   = 0;
        dones    = 0;
        applyStimulus(1'b1, op, a, b, 64'h0, 1'b0);
        for (int c = 0; c < 60 && !finished; c++) begin
            if (bus.stall_o) stalls++;
            if (bus.done_o) dones++;
            if (!bus.stall_o) finished = 1'b1;
            stepClock();
        end
        applyIdle();
        checkOutput({tag, "_finished"}, 32'(finished), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        applyIdle();
        stepClock();
        stepClock();
        checkOutput("rst_hi", bus.hi_o, 32'h0);
        checkOutput("rst_lo", bus.lo_o, 32'h0);
        checkOutput("rst_stall", 32'(bus.stall_o), 32'd0);
        checkOutput("rst_done", 32'(bus.done_o), 32'd0);
        rst = 1'b0;
        stepClock();

        // MULT commits the supplied product with no stall
        applyStimulus(1'b1, EXE_MULT_OP, 32'hFFFF_FFFD, 32'h5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
        checkOutput("mult_stall", 32'(bus.stall_o), 32'd0);
        stepClock();
        applyIdle();
        checkOutput("mult_hi", bus.hi_o, 32'hFFFF_FFFF);
        checkOutput("mult_lo", bus.lo_o, 32'hFFFF_FFF1);
        checkOutput("mult_stall_after", 32'(bus.stall_o), 32'd0);

        applyStimulus(1'b1, EXE_MULTU_OP, 32'h2, 32'h2, 64'h0000_0004_0000_0002, 1'b0);
        stepClock();
        applyIdle();
        checkOutput("multu_hi", bus.hi_o, 32'h4);
        checkOutput("multu_lo", bus.lo_o, 32'h2);

        // DIVU 100 / 7
        runDiv("divu", EXE_DIVU_OP, 32'd100, 32'd7, stallCycles, doneCycles);
        checkOutput("divu_stalls", 32'(stallCycles), 32'd33);
        checkOutput("divu_dones", 32'(doneCycles), 32'd1);
        checkOutput("divu_lo", bus.lo_o, 32'd14);
        checkOutput("divu_hi", bus.hi_o, 32'd2);
        checkOutput("divu_done_after", 32'(bus.done_o), 32'd0);

        // DIV -7 / 2 -> q=-3, r=-1
        runDiv("div_neg", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, stallCycles, doneCycles);
        checkOutput("div_neg_stalls", 32'(stallCycles), 32'd33);
        checkOutput("div_neg_lo", bus.lo_o, 32'hFFFF_FFFD);
        checkOutput("div_neg_hi", bus.hi_o, 32'hFFFF_FFFF);

        // DIV 7 / -2 -> q=-3, r=+1 (remainder follows dividend sign)
        runDiv("div_negb", EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, stallCycles, doneCycles);
        checkOutput("div_negb_lo", bus.lo_o, 32'hFFFF_FFFD);
        checkOutput("div_negb_hi", bus.hi_o, 32'd1);

        // Most negative / -1 wraps
        runDiv("div_min", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, stallCycles, doneCycles);
        checkOutput("div_min_lo", bus.lo_o, 32'h8000_0000);
        checkOutput("div_min_hi", bus.hi_o, 32'h0);

        // DIVU treats operands as unsigned
        runDiv("divu_big", EXE_DIVU_OP, 32'hFFFF_FFFF, 32'h10, stallCycles, doneCycles);
        checkOutput("divu_big_lo", bus.lo_o, 32'h0FFF_FFFF);
        checkOutput("divu_big_hi", bus.hi_o, 32'hF);

        // Divide by zero commits immediately
        runDiv("div_zero", EXE_DIV_OP, 32'd5, 32'd0, stallCycles, doneCycles);
        checkOutput("div_zero_stalls", 32'(stallCycles), 32'd0);
        checkOutput("div_zero_dones", 32'(doneCycles), 32'd1);
        checkOutput("div_zero_hi", bus.hi_o, 32'd5);
        checkOutput("div_zero_lo", bus.lo_o, 32'hFFFF_FFFF);

        // Flush at BUSY step 10 leaves HI/LO untouched
        applyStimulus(1'b1, EXE_DIVU_OP, 32'd100, 32'd7, 64'h0, 1'b0);
        stepClock();
        for (int i = 0; i < 10; i++) stepClock();
        applyStimulus(1'b1, EXE_DIVU_OP, 32'd100, 32'd7, 64'h0, 1'b1);
        checkOutput("flush_stall", 32'(bus.stall_o), 32'd0);
        checkOutput("flush_done", 32'(bus.done_o), 32'd0);
        stepClock();
        applyIdle();
        checkOutput("flush_idle_stall", 32'(bus.stall_o), 32'd0);
        checkOutput("flush_hi", bus.hi_o, 32'd5);
        checkOutput("flush_lo", bus.lo_o, 32'hFFFF_FFFF);
        for (int i = 0; i < 40; i++) stepClock();
        checkOutput("flush_hi_later", bus.hi_o, 32'd5);
        checkOutput("flush_lo_later", bus.lo_o, 32'hFFFF_FFFF);

        // Reset mid-division clears HI/LO
        applyStimulus(1'b1, EXE_DIVU_OP, 32'd100, 32'd7, 64'h0, 1'b0);
        stepClock();
        for (int i = 0; i < 10; i++) stepClock();
        rst = 1'b1;
        stepClock();
        rst = 1'b0;
        applyIdle();
        checkOutput("rstdiv_stall", 32'(bus.stall_o), 32'd0);
        checkOutput("rstdiv_hi", bus.hi_o, 32'h0);
        checkOutput("rstdiv_lo", bus.lo_o, 32'h0);

        // MTHI then MFHI
        applyStimulus(1'b1, EXE_MTHI_OP, 32'h1234, 32'h0, 64'h0, 1'b0);
        checkOutput("mthi_stall", 32'(bus.stall_o), 32'd0);
        stepClock();
        applyStimulus(1'b1, EXE_MFHI_OP, 32'h0, 32'h0, 64'h0, 1'b0);
        checkOutput("mfhi_rdata", bus.rdata_o, 32'h1234);
        stepClock();

        // MTLO then MFLO, then a flushed MTLO must not write
        applyStimulus(1'b1, EXE_MTLO_OP, 32'h5678, 32'h0, 64'h0, 1'b0);
        stepClock();
        applyStimulus(1'b1, EXE_MFLO_OP, 32'h0, 32'h0, 64'h0, 1'b0);
        checkOutput("mflo_rdata", bus.rdata_o, 32'h5678);
        stepClock();
        applyStimulus(1'b1, EXE_MTLO_OP, 32'h9999, 32'h0, 64'h0, 1'b1);
        stepClock();
        applyStimulus(1'b1, EXE_MFLO_OP, 32'h0, 32'h0, 64'h0, 1'b0);
        checkOutput("mtlo_flush_rdata", bus.rdata_o, 32'h5678);
        checkOutput("mtlo_flush_hi", bus.hi_o, 32'h1234);

        // Non-MF op reads zero
        applyStimulus(1'b0, EXE_MULT_OP, 32'h0, 32'h0, 64'h0, 1'b0);
        checkOutput("other_rdata", bus.rdata_o, 32'h0);
        stepClock();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
